// File: rtl/spi_regfile_periph.sv
// SPI mode-0 register-bank peripheral: framed writes, optional readback on MISO,
// write strobe and saturating frame-error counter. Readback built with `SPI_READBACK_EN`.
module spi_regfile_periph #(
  parameter int unsigned NUM_REGS = 8,
  parameter int unsigned ADDR_W   = 7,
  parameter int unsigned DATA_W   = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       sclk_raw,
  input  logic                       mosi_raw,
  input  logic                       cs_n_raw,
  output logic                       miso,
  output logic [NUM_REGS*DATA_W-1:0] regs_out,
  output logic                       wr_strobe,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic [7:0]                 err_count
);

  localparam int unsigned FRAME_W = 1 + ADDR_W + DATA_W;
  localparam int unsigned CNT_W   = $clog2(FRAME_W + 2);
  localparam logic [CNT_W-1:0]  CNT_FULL   = CNT_W'(FRAME_W);
  localparam logic [CNT_W-1:0]  CNT_SAT    = CNT_W'(FRAME_W + 1);
  localparam logic [ADDR_W:0]   NUM_REGS_L = (ADDR_W + 1)'(NUM_REGS);

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

  state_t             state_q, state_d;
  logic               cs_s1, cs_s2, cs_prev;
  logic               sclk_s1, sclk_s2, sclk_prev;
  logic               mosi_s1, mosi_s2;
  logic               sclk_rise, cs_rise, cs_fall;
  logic [CNT_W-1:0]   bit_cnt;
  logic [FRAME_W-1:0] sr;
  logic [DATA_W-1:0]  regs [NUM_REGS];
  logic               f_rw, f_in_range;
  logic [ADDR_W-1:0]  f_addr;
  logic [DATA_W-1:0]  f_data;
  logic               commit_frame, do_write, do_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      cs_s1     <= 1'b1;
      cs_s2     <= 1'b1;
      cs_prev   <= 1'b1;
      sclk_s1   <= 1'b0;
      sclk_s2   <= 1'b0;
      sclk_prev <= 1'b0;
      mosi_s1   <= 1'b0;
      mosi_s2   <= 1'b0;
    end else begin
      cs_s1     <= cs_n_raw;
      cs_s2     <= cs_s1;
      cs_prev   <= cs_s2;
      sclk_s1   <= sclk_raw;
      sclk_s2   <= sclk_s1;
      sclk_prev <= sclk_s2;
      mosi_s1   <= mosi_raw;
      mosi_s2   <= mosi_s1;
    end
  end

  assign sclk_rise = sclk_s2 & ~sclk_prev;
  assign cs_rise   = cs_s2 & ~cs_prev;
  assign cs_fall   = ~cs_s2 & cs_prev;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cs_fall) state_d = SHIFT;
      SHIFT:   if (cs_rise) state_d = COMMIT;
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign f_rw       = sr[FRAME_W-1];
  assign f_addr     = sr[FRAME_W-2 -: ADDR_W];
  assign f_data     = sr[DATA_W-1:0];
  assign f_in_range = {1'b0, f_addr} < NUM_REGS_L;

  // Commit is decided on the SHIFT->COMMIT edge so that the register
  // updates land two clocks after the raw CS rise is sampled.
  assign commit_frame = (state_q == SHIFT) && cs_rise;

  always_comb begin
    do_write = 1'b0;
    do_err   = 1'b0;
    if (commit_frame) begin
      if (bit_cnt == CNT_FULL) begin
        if (!f_in_range) do_err = 1'b1;
        else if (f_rw)   do_write = 1'b1;
      end else if (bit_cnt != '0) begin
        do_err = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt   <= '0;
      sr        <= '0;
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
      err_count <= '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      wr_strobe <= do_write;
      if (state_q != SHIFT) begin
        bit_cnt <= '0;
      end else if (sclk_rise && !cs_s2) begin
        sr <= {sr[FRAME_W-2:0], mosi_s2};
        if (bit_cnt != CNT_SAT) bit_cnt <= bit_cnt + 1'b1;
      end
      if (do_write) begin
        wr_addr <= f_addr;
        for (int unsigned i = 0; i < NUM_REGS; i++)
          if (f_addr == ADDR_W'(i)) regs[i] <= f_data;
      end
      if (do_err && err_count != 8'hFF) err_count <= err_count + 8'd1;
    end
  end

  always_comb begin
    regs_out = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++)
      regs_out[i*DATA_W +: DATA_W] = regs[i];
  end

`ifdef SPI_READBACK_EN
  logic              sclk_fall, ld_done, r_in_range;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] rd_data, out_sr;

  assign sclk_fall  = ~sclk_s2 & sclk_prev;
  // Once R/W and address are in, they sit in the low bits of the shifter.
  assign r_addr     = sr[ADDR_W-1:0];
  assign r_in_range = {1'b0, r_addr} < NUM_REGS_L;

  always_comb begin
    rd_data = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++)
      if (r_addr == ADDR_W'(i)) rd_data = regs[i];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_sr  <= '0;
      ld_done <= 1'b0;
      miso    <= 1'b0;
    end else if (state_q != SHIFT || cs_s2) begin
      out_sr  <= '0;
      ld_done <= 1'b0;
      miso    <= 1'b0;
    end else if (!ld_done && bit_cnt == CNT_W'(1 + ADDR_W)) begin
      ld_done <= 1'b1;
      out_sr  <= (!sr[ADDR_W] && r_in_range) ? rd_data : '0;
    end else if (sclk_fall) begin
      miso   <= out_sr[DATA_W-1];
      out_sr <= {out_sr[DATA_W-2:0], 1'b0};
    end
  end
`else
  assign miso = 1'b0;
`endif

endmodule

// File: tb/tb_spi_regfile_periph.sv
// Directed self-checking bench for spi_regfile_periph (default parameters);
// miso expectations follow whether SPI_READBACK_EN is defined.
module tb_spi_regfile_periph;

  localparam int HP = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sclk_raw = 1'b0;
  logic        mosi_raw = 1'b0;
  logic        cs_n_raw = 1'b1;
  logic        miso;
  logic [63:0] regs_out;
  logic        wr_strobe;
  logic [6:0]  wr_addr;
  logic [7:0]  err_count;

  int n_tests = 0;
  int n_fail  = 0;
  int stb_total = 0;
  logic [31:0] cap;
  logic [7:0]  rb_3c, rb_ff;

  spi_regfile_periph #(.NUM_REGS(8), .ADDR_W(7), .DATA_W(8)) dut (
    .clk(clk), .rst(rst), .sclk_raw(sclk_raw), .mosi_raw(mosi_raw),
    .cs_n_raw(cs_n_raw), .miso(miso), .regs_out(regs_out),
    .wr_strobe(wr_strobe), .wr_addr(wr_addr), .err_count(err_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (!rst && wr_strobe) stb_total++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Sends n bits of v MSB first; cap collects miso sampled just before each rise.
  task automatic spi_frame(input int n, input logic [31:0] v, input logic exp_stb,
                           output logic [31:0] c);
    c = '0;
    cs_n_raw = 1'b0;
    wait_clk(HP);
    for (int i = n - 1; i >= 0; i--) begin
      mosi_raw = v[i];
      wait_clk(HP);
      c = {c[30:0], miso};
      sclk_raw = 1'b1;
      wait_clk(HP);
      sclk_raw = 1'b0;
    end
    wait_clk(HP);
    cs_n_raw = 1'b1;
    wait_clk(2);
    check("stb_early", {63'd0, wr_strobe}, 64'd0);
    wait_clk(1);
    check("stb_k2", {63'd0, wr_strobe}, {63'd0, exp_stb});
    wait_clk(1);
    check("stb_len", {63'd0, wr_strobe}, 64'd0);
    wait_clk(HP);
  endtask

  initial begin
`ifdef SPI_READBACK_EN
    rb_3c = 8'h3C;
    rb_ff = 8'hFF;
`else
    rb_3c = 8'h00;
    rb_ff = 8'h00;
`endif
    wait_clk(3);
    rst = 1'b0;
    wait_clk(2);
    check("rst_regs", regs_out, 64'd0);
    check("rst_err", {56'd0, err_count}, 64'd0);
    check("rst_waddr", {57'd0, wr_addr}, 64'd0);
    check("rst_miso", {63'd0, miso}, 64'd0);

    spi_frame(16, 32'h82A5, 1'b1, cap);
    check("wr2_regs", regs_out, 64'h0000_0000_00A5_0000);
    check("wr2_addr", {57'd0, wr_addr}, 64'd2);
    check("wr2_err", {56'd0, err_count}, 64'd0);

    spi_frame(16, 32'h853C, 1'b1, cap);
    check("wr5_regs", regs_out, 64'h0000_3C00_00A5_0000);

    spi_frame(16, 32'h0500, 1'b0, cap);
    check("rd5_miso", {48'd0, cap[15:0]}, {56'd0, rb_3c});
    check("rd5_regs", regs_out, 64'h0000_3C00_00A5_0000);
    check("rd5_err", {56'd0, err_count}, 64'd0);

    spi_frame(16, 32'h8811, 1'b0, cap);
    check("wr8_regs", regs_out, 64'h0000_3C00_00A5_0000);
    check("wr8_err", {56'd0, err_count}, 64'd1);
    check("wr8_addr", {57'd0, wr_addr}, 64'd5);

    spi_frame(15, 32'h4152, 1'b0, cap);
    check("len15_err", {56'd0, err_count}, 64'd2);
    spi_frame(17, 32'h10A77, 1'b0, cap);
    check("len17_err", {56'd0, err_count}, 64'd3);
    check("len_regs", regs_out, 64'h0000_3C00_00A5_0000);

    spi_frame(0, 32'h0, 1'b0, cap);
    check("glitch_err", {56'd0, err_count}, 64'd3);

    spi_frame(16, 32'h0800, 1'b0, cap);
    check("rd8_err", {56'd0, err_count}, 64'd4);
    check("rd8_miso", {32'd0, cap}, 64'd0);

    spi_frame(16, 32'h80FF, 1'b1, cap);
    check("wr0_regs", regs_out, 64'h0000_3C00_00A5_00FF);
    check("wr0_addr", {57'd0, wr_addr}, 64'd0);
    spi_frame(16, 32'h0000, 1'b0, cap);
    check("rd0_miso", {48'd0, cap[15:0]}, {56'd0, rb_ff});
    check("rd0_err", {56'd0, err_count}, 64'd4);

    // Reset after 9 bits of a write to addr 1, then release CS with no more clocks.
    cs_n_raw = 1'b0;
    wait_clk(HP);
    for (int i = 15; i >= 7; i--) begin
      mosi_raw = logic'((16'h8177 >> i) & 16'h1);
      wait_clk(HP);
      sclk_raw = 1'b1;
      wait_clk(HP);
      sclk_raw = 1'b0;
    end
    wait_clk(HP);
    rst = 1'b1;
    wait_clk(2);
    rst = 1'b0;
    wait_clk(HP);
    cs_n_raw = 1'b1;
    wait_clk(8);
    check("mid_rst_regs", regs_out, 64'd0);
    check("mid_rst_err", {56'd0, err_count}, 64'd0);
    check("mid_rst_stb", stb_total, 64'd3);

    spi_frame(16, 32'h815A, 1'b1, cap);
    check("post_rst_regs", regs_out, 64'h0000_0000_0000_5A00);
    check("post_rst_addr", {57'd0, wr_addr}, 64'd1);

    for (int j = 0; j < 300; j++) spi_frame(16, 32'h8811, 1'b0, cap);
    check("sat_err", {56'd0, err_count}, 64'd255);
    check("sat_regs", regs_out, 64'h0000_0000_0000_5A00);
    check("stb_total", stb_total, 64'd4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
